// File: rtl/instruction_decoder_pkg.sv
// Shared constants and types for the 49-bit instruction decoder.
// Optional build macro: INSTRUCTION_DECODER_R0_GUARD_EN (register 0 read-only).
package instruction_decoder_pkg;

    localparam int INSTR_W    = 49;
    localparam int OPCODE_MSB = 48;
    localparam int OPCODE_LSB = 44;
    localparam int MODE_MSB   = 43;
    localparam int MODE_LSB   = 42;
    localparam int DST_MSB    = 41;
    localparam int DST_LSB    = 37;
    localparam int A_MSB      = 36;
    localparam int A_LSB      = 32;
    localparam int B_MSB      = 31;
    localparam int B_LSB      = 0;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int DST_W    = DST_MSB - DST_LSB + 1;
    localparam int A_W      = A_MSB - A_LSB + 1;
    localparam int A_SEL_W  = 8;
    localparam int B_W      = B_MSB - B_LSB + 1;

    typedef enum logic [4:0] {
        OP_NOP = 5'h00,
        OP_LD  = 5'h01,
        OP_ST  = 5'h02,
        OP_ADD = 5'h03,
        OP_SUB = 5'h04,
        OP_AND = 5'h05,
        OP_OR  = 5'h06,
        OP_XOR = 5'h07,
        OP_NOT = 5'h08,
        OP_SL  = 5'h09,
        OP_SR  = 5'h0A,
        OP_BZ  = 5'h10,
        OP_BNZ = 5'h11,
        OP_BRA = 5'h12
    } opcode_t;

    // Bit 1 selects the literal as B, bit 0 routes data through RAM.
    typedef enum logic [1:0] {
        MODE_REG_REG = 2'b00,
        MODE_REG_MEM = 2'b01,
        MODE_LIT_REG = 2'b10,
        MODE_LIT_MEM = 2'b11
    } addr_mode_t;

    typedef struct packed {
        logic mux_b_addr;
        logic ram_read_mux;
        logic store_decoder;
        logic ram_ena;
        logic ram_wena;
        logic register_load;
        logic branch;
    } ctrl_t;

    function automatic logic mode_lit(input addr_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic mode_mem(input addr_mode_t mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/instruction_decoder_ctrl_lut.sv
// Combinational opcode/mode/Z/DST to control-strobe mapping.
// Honours INSTRUCTION_DECODER_R0_GUARD_EN to block writes to register 0.
module decoder_ctrl_lut
    import instruction_decoder_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  addr_mode_t          mode,
    input  logic                z,
    input  logic [DST_W-1:0]    dst,
    output ctrl_t               ctrl
);

`ifdef INSTRUCTION_DECODER_R0_GUARD_EN
    localparam logic R0_GUARD = 1'b1;
`else
    localparam logic R0_GUARD = 1'b0;
`endif

    logic  r0_blocked;
    ctrl_t raw;

    assign r0_blocked = R0_GUARD & (dst == '0);

    // Unlisted or unknown opcodes fall to the default arm and stay all-zero.
    always_comb begin
        raw = '0;
        case (opcode_t'(opcode))
            OP_LD: begin
                raw.mux_b_addr    = mode_lit(mode);
                raw.ram_read_mux  = mode_mem(mode);
                raw.ram_ena       = mode_mem(mode);
                raw.register_load = 1'b1;
            end
            OP_ST: begin
                raw.mux_b_addr    = mode_lit(mode);
                raw.ram_read_mux  = mode_mem(mode);
                raw.store_decoder = 1'b1;
                raw.ram_ena       = 1'b1;
                raw.ram_wena      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SL, OP_SR: begin
                raw.mux_b_addr    = mode_lit(mode);
                raw.ram_read_mux  = mode_mem(mode);
                raw.ram_ena       = mode_mem(mode);
                raw.register_load = 1'b1;
            end
            OP_BZ: begin
                raw.mux_b_addr   = mode_lit(mode);
                raw.ram_read_mux = mode_mem(mode);
                raw.branch       = z;
            end
            OP_BNZ: begin
                raw.mux_b_addr   = mode_lit(mode);
                raw.ram_read_mux = mode_mem(mode);
                raw.branch       = ~z;
            end
            OP_BRA: begin
                raw.mux_b_addr   = mode_lit(mode);
                raw.ram_read_mux = mode_mem(mode);
                raw.branch       = 1'b1;
            end
            default: raw = '0;
        endcase
    end

    always_comb begin
        ctrl = raw;
        ctrl.register_load = raw.register_load & ~r0_blocked;
    end

endmodule

// File: rtl/instruction_decoder.sv
// Registered instruction decoder: fields and strobes valid one clock after capture.
// Optional build macro: INSTRUCTION_DECODER_R0_GUARD_EN (see decoder_ctrl_lut).
module instruction_decoder
    import instruction_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                Z,
    output logic [OPCODE_W-1:0] opcode,
    output logic [A_SEL_W-1:0]  A_Sel,
    output logic [B_W-1:0]      B_Sel,
    output logic [DST_W-1:0]    DST,
    output logic                MUX_B_ADDR,
    output logic                RAM_READ_MUX,
    output logic                STORE_DECODER,
    output logic                RAM_ENA,
    output logic                RAM_WENA,
    output logic                register_load,
    output logic                branch
);

    logic [OPCODE_W-1:0] opcode_field;
    addr_mode_t          mode_field;
    logic [DST_W-1:0]    dst_field;
    logic [A_W-1:0]      a_field;
    logic [B_W-1:0]      b_field;
    ctrl_t               ctrl_next;

    assign opcode_field = instruction[OPCODE_MSB:OPCODE_LSB];
    assign mode_field   = addr_mode_t'(instruction[MODE_MSB:MODE_LSB]);
    assign dst_field    = instruction[DST_MSB:DST_LSB];
    assign a_field      = instruction[A_MSB:A_LSB];
    assign b_field      = instruction[B_MSB:B_LSB];

    decoder_ctrl_lut u_ctrl_lut (
        .opcode (opcode_field),
        .mode   (mode_field),
        .z      (Z),
        .dst    (dst_field),
        .ctrl   (ctrl_next)
    );

    // Reset wins over any instruction in flight; otherwise capture every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode        <= '0;
            A_Sel         <= '0;
            B_Sel         <= '0;
            DST           <= '0;
            MUX_B_ADDR    <= 1'b0;
            RAM_READ_MUX  <= 1'b0;
            STORE_DECODER <= 1'b0;
            RAM_ENA       <= 1'b0;
            RAM_WENA      <= 1'b0;
            register_load <= 1'b0;
            branch        <= 1'b0;
        end else begin
            opcode        <= opcode_field;
            A_Sel         <= {{(A_SEL_W - A_W){1'b0}}, a_field};
            B_Sel         <= b_field;
            DST           <= dst_field;
            MUX_B_ADDR    <= ctrl_next.mux_b_addr;
            RAM_READ_MUX  <= ctrl_next.ram_read_mux;
            STORE_DECODER <= ctrl_next.store_decoder;
            RAM_ENA       <= ctrl_next.ram_ena;
            RAM_WENA      <= ctrl_next.ram_wena;
            register_load <= ctrl_next.register_load;
            branch        <= ctrl_next.branch;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed plan cases plus random back-to-back traffic.
// Output vector layout: {opcode, A_Sel, B_Sel, DST, MUX_B, RAM_RD_MUX, STORE, RAM_ENA, RAM_WENA, REG_LOAD, BRANCH}.
module tb_instruction_decoder;

    logic        clk;
    logic        reset;
    logic [48:0] instruction;
    logic        Z;
    logic [4:0]  opcode;
    logic [7:0]  A_Sel;
    logic [31:0] B_Sel;
    logic [4:0]  DST;
    logic        MUX_B_ADDR;
    logic        RAM_READ_MUX;
    logic        STORE_DECODER;
    logic        RAM_ENA;
    logic        RAM_WENA;
    logic        register_load;
    logic        branch;

    logic [56:0] observed;
    int          n_checks = 0;
    int          n_fail   = 0;

    instruction_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .Z             (Z),
        .opcode        (opcode),
        .A_Sel         (A_Sel),
        .B_Sel         (B_Sel),
        .DST           (DST),
        .MUX_B_ADDR    (MUX_B_ADDR),
        .RAM_READ_MUX  (RAM_READ_MUX),
        .STORE_DECODER (STORE_DECODER),
        .RAM_ENA       (RAM_ENA),
        .RAM_WENA      (RAM_WENA),
        .register_load (register_load),
        .branch        (branch)
    );

    assign observed = {opcode, A_Sel, B_Sel, DST, MUX_B_ADDR, RAM_READ_MUX,
                       STORE_DECODER, RAM_ENA, RAM_WENA, register_load, branch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: classify the opcode by numeric range and derive each output from the rules.
    function automatic logic [56:0] model(input logic [48:0] ins, input logic zf);
        int   op;
        int   md;
        int   dst;
        bit   is_ld, is_st, is_alu, is_br, legal;
        bit   mux_b, rd_mux, store, ena, wena, rload, br;
        op  = int'(ins[48:44]);
        md  = int'(ins[43:42]);
        dst = int'(ins[41:37]);
        is_ld  = (op == 1);
        is_st  = (op == 2);
        is_alu = (op >= 3) && (op <= 10);
        is_br  = (op >= 16) && (op <= 18);
        legal  = is_ld || is_st || is_alu || is_br;
        mux_b  = legal && (md >= 2);
        rd_mux = legal && (md % 2 == 1);
        store  = is_st;
        wena   = is_st;
        ena    = is_st || ((is_ld || is_alu) && (md % 2 == 1));
        rload  = is_ld || is_alu;
`ifdef INSTRUCTION_DECODER_R0_GUARD_EN
        if (dst == 0) rload = 1'b0;
`endif
        br = (op == 16) ? zf : (op == 17) ? !zf : (op == 18);
        return {ins[48:44], 3'b000, ins[36:32], ins[31:0], ins[41:37],
                mux_b, rd_mux, store, ena, wena, rload, br};
    endfunction

    task automatic applyStimulus(input logic [48:0] ins, input logic zf);
        @(negedge clk);
        instruction = ins;
        Z           = zf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        instruction = '0;
        Z           = 1'b0;
        #3;
        n_checks++;
        if (observed !== 57'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_initial: got %h expected %h", observed, 57'd0);
        end
        @(negedge clk);
        instruction = 49'h0_3041_00000001;
        @(posedge clk);
        #1;
        n_checks++;
        if (observed !== 57'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_holds: got %h expected %h", observed, 57'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_plan_ops();
        logic [48:0] ins_tab [4];
        logic [56:0] exp_tab [4];
        string       name_tab [4];
        ins_tab[0] = 49'h0_3041_00000001;
        exp_tab[0] = {5'h03, 8'h01, 32'h00000001, 5'd2,  7'b0000010};
        name_tab[0] = "add_reg";
        ins_tab[1] = 49'h0_391F_0000000A;
        exp_tab[1] = {5'h03, 8'h1F, 32'h0000000A, 5'd8,  7'b1000010};
        name_tab[1] = "add_lit";
        ins_tab[2] = 49'h0_141D_1234DADA;
        exp_tab[2] = {5'h01, 8'h1D, 32'h1234DADA, 5'd0,  7'b0101010};
        name_tab[2] = "ld_mem";
        ins_tab[3] = 49'h0_27A0_00000010;
        exp_tab[3] = {5'h02, 8'h00, 32'h00000010, 5'd29, 7'b0111100};
        name_tab[3] = "st_mem";
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ins_tab[i], 1'b0);
            n_checks++;
            if (observed !== exp_tab[i]) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", name_tab[i], observed, exp_tab[i]);
            end
        end
    endtask

    task automatic test_branches();
        logic [48:0] ins_tab [3];
        logic        br_tab  [2][3];
        ins_tab[0] = 49'h1_0000_00000010;
        ins_tab[1] = 49'h1_1000_00000010;
        ins_tab[2] = 49'h1_2000_00000010;
        br_tab[0][0] = 1'b0; br_tab[0][1] = 1'b1; br_tab[0][2] = 1'b1;
        br_tab[1][0] = 1'b1; br_tab[1][1] = 1'b0; br_tab[1][2] = 1'b1;
        for (int zv = 1; zv >= 0; zv--) begin
            for (int i = 0; i < 3; i++) begin
                applyStimulus(ins_tab[i], zv[0]);
                n_checks++;
                if ({MUX_B_ADDR, RAM_READ_MUX, STORE_DECODER, RAM_ENA, RAM_WENA,
                     register_load, branch} !== {6'b000000, br_tab[zv][i]}) begin
                    n_fail++;
                    $display("[TB] FAIL branch_op%0d_z%0d: got strobes %b expected %b", i, zv,
                             {MUX_B_ADDR, RAM_READ_MUX, STORE_DECODER, RAM_ENA, RAM_WENA,
                              register_load, branch}, {6'b000000, br_tab[zv][i]});
                end
                n_checks++;
                if (opcode !== ins_tab[i][48:44] || B_Sel !== 32'h10) begin
                    n_fail++;
                    $display("[TB] FAIL branch_fields%0d: got opcode %h B %h expected %h %h", i,
                             opcode, B_Sel, ins_tab[i][48:44], 32'h10);
                end
            end
        end
    endtask

    task automatic test_r0_write();
        logic [48:0] ins;
        logic [56:0] exp;
        ins = 49'h0_4000_00000003;
        exp = model(ins, 1'b0);
        applyStimulus(ins, 1'b0);
        n_checks++;
        if (observed !== exp) begin
            n_fail++;
            $display("[TB] FAIL r0_write: got %h expected %h", observed, exp);
        end
    endtask

    task automatic test_mid_cycle_reset();
        logic [56:0] exp;
        exp = {5'h03, 8'h01, 32'h00000001, 5'd2, 7'b0000010};
        applyStimulus(49'h0_3041_00000001, 1'b0);
        n_checks++;
        if (observed !== exp) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_add: got %h expected %h", observed, exp);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (observed !== 57'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected %h", observed, 57'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(49'h0_0C00_00000000, 1'b1);
        n_checks++;
        if (observed !== 57'd0) begin
            n_fail++;
            $display("[TB] FAIL nop_after_reset: got %h expected %h", observed, 57'd0);
        end
    endtask

    // Random instructions every cycle; opcode drawn to hit legal ops and NOPs alike.
    task automatic test_back_to_back();
        logic [48:0] ins;
        logic        zf;
        logic [56:0] exp;
        for (int i = 0; i < 400; i++) begin
            ins = {$urandom, $urandom, $urandom};
            if (($urandom % 4) != 0)
                ins[48:44] = 5'($urandom_range(0, 18));
            zf  = 1'($urandom);
            exp = model(ins, zf);
            applyStimulus(ins, zf);
            n_checks++;
            if (observed !== exp) begin
                n_fail++;
                $display("[TB] FAIL random_%0d ins=%h z=%b: got %h expected %h",
                         i, ins, zf, observed, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan_ops();
        test_branches();
        test_r0_write();
        test_mid_cycle_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
